// File: rtl/router_pkg.sv
// Shared router definitions: port indices, flit geometry and VC buffer state encoding.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_N    = 0;
  localparam int PORT_S    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_PE   = 4;

  localparam int DATA_W    = 64;
  localparam int VC_BIT    = 63;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/router_output_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found_s;
  int   idx_s;

  // Upward search from ptr; the first hit wins.
  always_comb begin
    grant   = {N{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr) + k) % N;
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Router output port: two one-flit VC buffers filled by round-robin on polarity p
// and drained to the link on polarity ~p.
module router_output_arbiter #(
  parameter int NUM_REQ = router_pkg::NUM_PORTS,
  parameter int DATA_W  = router_pkg::DATA_W,
  parameter int VC_BIT  = router_pkg::VC_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      polarity,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      so_ready,
  output logic                      so_send,
  output logic [DATA_W-1:0]         so_data
);

  import router_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  buf_state_e         state_r     [2];
  buf_state_e         state_nxt_s [2];
  logic [DATA_W-1:0]  buf_data_r  [2];
  logic [PTR_W-1:0]   ptr_r       [2];
  logic               active_r;

  logic [NUM_REQ-1:0] elig_s      [2];
  logic [NUM_REQ-1:0] arb_grant_s [2];
  logic               fill_s;
  logic               drain_s;
  logic               drain_vc_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [PTR_W-1:0]   ptr_nxt_s;
  logic [DATA_W-1:0]  grant_flit_s;

  // Per-VC eligibility from request and the flit's VC select bit.
  always_comb begin
    elig_s[0] = {NUM_REQ{1'b0}};
    elig_s[1] = {NUM_REQ{1'b0}};
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        elig_s[v][i] = req[i] && (data_in[i*DATA_W + VC_BIT] == 1'(v));
      end
    end
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc_arb
    rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
    ) u_rr_vc (
      .req   (elig_s[v]),
      .ptr   (ptr_r[v]),
      .grant (arb_grant_s[v])
    );
  end

  // Internal side: grant only into an empty buffer of the current polarity.
  // active_r masks the reset cycle and the first cycle after release.
  always_comb begin
    fill_s       = active_r && (state_r[polarity] == BUF_EMPTY) && (|arb_grant_s[polarity]);
    grant        = fill_s ? arb_grant_s[polarity] : {NUM_REQ{1'b0}};
    grant_idx_s  = {PTR_W{1'b0}};
    grant_flit_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx_s  = PTR_W'(i);
        grant_flit_s = data_in[i*DATA_W +: DATA_W];
      end else begin
        grant_idx_s  = grant_idx_s;
      end
    end
    ptr_nxt_s = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : grant_idx_s + PTR_W'(1);
  end

  // External side: the opposite-polarity buffer drains when the link is ready.
  always_comb begin
    drain_vc_s = ~polarity;
    drain_s    = active_r && (state_r[drain_vc_s] == BUF_FULL) && so_ready;
    so_send    = drain_s;
    so_data    = drain_s ? buf_data_r[drain_vc_s] : {DATA_W{1'b0}};
  end

  // Per-VC buffer FSM next state.
  always_comb begin
    state_nxt_s[0] = BUF_EMPTY;
    state_nxt_s[1] = BUF_EMPTY;
    for (int v = 0; v < 2; v++) begin
      case (state_r[v])
        BUF_EMPTY: state_nxt_s[v] = (fill_s && (polarity == 1'(v))) ? BUF_FULL : BUF_EMPTY;
        BUF_FULL:  state_nxt_s[v] = (drain_s && (polarity != 1'(v))) ? BUF_EMPTY : BUF_FULL;
        default:   state_nxt_s[v] = BUF_EMPTY;
      endcase
    end
  end

  // State, buffer data and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        state_r[v]    <= BUF_EMPTY;
        buf_data_r[v] <= {DATA_W{1'b0}};
        ptr_r[v]      <= {PTR_W{1'b0}};
      end
    end else begin
      active_r <= 1'b1;
      for (int v = 0; v < 2; v++) begin
        state_r[v] <= state_nxt_s[v];
      end
      if (fill_s) begin
        buf_data_r[polarity] <= grant_flit_s;
        ptr_r[polarity]      <= ptr_nxt_s;
      end
    end
  end

endmodule

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Shares one router output port between NUM_REQ input channels (N, S, E, W, PE) of the mesh NoC router.
- Holds a one-flit output buffer per virtual channel (VC0/VC1). Fills them by round-robin arbitration and drains them to the downstream link.
- Uses the global even/odd polarity convention:
  - In a cycle with polarity p, buffer p fills from the inputs (internal side).
  - In the same cycle, buffer ~p drains to the link (external side).
- Sits between the router_input_channel instances and the inter-router link.

Parameters:
- NUM_REQ, 5, number of requesting input channels
- DATA_W, 64, flit width
- VC_BIT, 63, bit of a flit that selects its VC (0 or 1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- polarity  input  1  global phase; toggles every cycle
- req  input  NUM_REQ  req[i]=1: input channel i holds a flit routed to this output
- data_in  input  NUM_REQ*DATA_W  flattened flits; channel i at [i*DATA_W +: DATA_W]
- grant  output  NUM_REQ  one-hot pop strobe; channel i's flit is taken at this clock edge
- so_ready  input  1  downstream can accept a flit this cycle
- so_send  output  1  flit valid on so_data this cycle
- so_data  output  DATA_W  outgoing flit; 0 when so_send=0

Behaviour:
- Reset (async, active-high):
  - Both VC buffers EMPTY, buffer data 0.
  - Both round-robin pointers = 0.
  - grant=0, so_send=0, so_data=0 while reset is high and in the first cycle after release.
- Per-VC buffer FSM, states EMPTY and FULL:
  - EMPTY -> FULL: at the posedge of a polarity==v cycle in which a grant for VC v is issued.
  - FULL -> EMPTY: at the posedge of a polarity==~v cycle in which so_send=1.
  - Fill and drain of the same buffer never coincide, because they happen on opposite polarities.
- Eligibility for VC v = polarity: req[i]=1 and data_in[i][VC_BIT]==v.
- Arbitration (combinational from state and inputs):
  - If buffer[polarity] is EMPTY and at least one channel is eligible, grant the first eligible index searching upward from ptr[polarity], wrapping NUM_REQ-1 -> 0.
  - Exactly one grant bit may be high; grant is 0 otherwise.
  - On a grant to index g: the buffer latches that flit and ptr[polarity] becomes (g+1) mod NUM_REQ at the clock edge.
  - A pointer changes only on a grant to its own VC.
- Drain (combinational):
  - so_send = buffer[~polarity] FULL && so_ready.
  - so_data = buffer[~polarity] data when so_send=1, else 0.
  - If so_ready=0, the buffer stays FULL and retries on the next cycle of the same polarity (two cycles later).
- Latency: minimum 1 cycle from grant edge to so_send (grant on polarity p, drain in the next cycle, polarity ~p).
- Throughput: at most one flit per VC per two cycles; one flit per cycle aggregate.
- A requester whose VC buffer is FULL receives no grant; its req is held and starvation is bounded by round-robin order.
- Reset asserted mid-transfer: buffered flits are discarded; no grant or so_send in the reset cycle.
- Flits are passed unmodified; no width conversion.

Decomposition:
- Shared package router_pkg holds:
  - NUM_PORTS=5 and the port indices PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_PE=4.
  - DATA_W, VC_BIT.
  - The VC buffer state encoding (EMPTY=0, FULL=1).
- One sub-module, rr_arbiter:
  - Inputs: request vector, pointer. Output: one-hot grant.
  - Purely combinational; instantiated twice, once per VC, with the output muxed by polarity.
  - Pointer registers stay in the parent.

Test Plan:
- Reset: hold reset for 2 cycles with req=5'b11111 -> grant=0, so_send=0, so_data=0 throughout; after release the first grant goes to index 0.
- Round-robin: req=5'b11111 with all flits VC0 (bit63=0), so_ready=1 -> grants on polarity-0 cycles go to 0,1,2,3,4,0 in order; each flit appears on so_data in the following cycle.
- VC split: ch1 sends 64'h0000_0000_0000_6840 (VC0), ch3 sends 64'h8000_0000_0000_FFFF (VC1) -> ch1 granted on the polarity-0 cycle, ch3 on the polarity-1 cycle; so_data shows 6840 then 8000..FFFF in consecutive cycles.
- Backpressure: fill VC0 with 64'hABCDEF, hold so_ready=0 for 4 cycles -> so_send=0, no further VC0 grants, buffer keeps ABCDEF; when so_ready rises, ABCDEF is sent on the next polarity-1 cycle.
- Reset mid-operation: both buffers FULL, assert reset for 1 cycle -> no so_send for the held flits; pointers return to 0; next grant goes to the lowest eligible index.
- Sparse requests: only ch4 requesting, then only ch2 -> ch4 granted, ptr wraps to 0, ch2 granted next; grant is never multi-hot.
